ray_hit_scoreboard: RTL and testbench
=====================================

# ray_hit_scoreboard

Synthesizable, parametrised result checker for the Ray_AABB intersection pipelines. It takes the high-precision reference hit/miss bit of each ray when the ray is issued and delays it by the unit's pipeline latency. It then compares that bit against the unit's `hit_miss` output and keeps saturating Type-1 and Type-2 error counts across one or more parallel lanes. It sits beside a ray-box unit on the evaluation board or in a bench, so that accuracy runs over `NUM_RAYS` rays report their totals in hardware.

## Interface
- `LANES`, 1: number of parallel ray-box units checked; each lane has one hit bit.
- `LATENCY`, 38: cycles from ray issue to valid `dut_hit`; legal range ≥1.
- `NUM_RAYS`, 10000: issue cycles accepted per run. Each issue cycle carries `LANES` rays.
- `CNT_W`, 16: width of the error counters.
- `IDX_W`, `$clog2(NUM_RAYS+1)`: width of the issue and check counters.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run.
- `ref_valid`, in, 1: a ray is issued to the units this cycle.
- `ref_hit`, in, `LANES`: high-precision result per lane for the issued ray.
- `dut_hit`, in, `LANES`: unit `hit_miss` outputs, one per lane.
- `busy`, out, 1: state is RUN or DRAIN.
- `done`, out, 1: state is DONE. The counters are final.
- `type1_cnt`, out, `CNT_W`: count of lanes with ref=1 and dut=0 (missed hit).
- `type2_cnt`, out, `CNT_W`: count of lanes with ref=0 and dut=1 (false hit).
- `checked_cnt`, out, `IDX_W`: issue cycles compared so far.
- `err_lane`, out, `LANES`: sticky flag per lane, set on any mismatch in that lane.
- `first_err_idx`, out, `IDX_W`: `checked_cnt` value at the first mismatch. Holds all-ones if no mismatch has occurred.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. On the same edge, clear all counters, `err_lane` and the issue counter, and set `first_err_idx` to all-ones.
- In RUN, each cycle with `ref_valid`=1 pushes {1, `ref_hit`} into the delay line and increments the issue counter. Cycles with `ref_valid`=0 push {0, x}.
- RUN → DRAIN on the edge that accepts issue number `NUM_RAYS`. From then on, `ref_valid` is ignored and the line is fed {0, x}.
- DRAIN → DONE on the edge where `checked_cnt` reaches `NUM_RAYS`.
- DONE → RUN on `start`, with the same clears as from IDLE.
- `start` is ignored in RUN and DRAIN.
- Delay line: `LATENCY` stages of (1 + `LANES`) bits.
- When a valid entry reaches the output stage, compare it per lane with `dut_hit` sampled on that edge:
  - mism1 = ref & ~dut.
  - mism2 = ~ref & dut.
- Add popcount(mism1) to `type1_cnt` and popcount(mism2) to `type2_cnt`.
  - Compute each sum in `CNT_W`+1 bits.
  - On overflow, clamp to 2^`CNT_W`−1. A counter stays saturated until the next clear.
- `checked_cnt` increments by 1 per valid output entry, regardless of `LANES`.
- `err_lane` |= mism1|mism2.
- If any mismatch occurs and `first_err_idx` is all-ones, load the pre-increment `checked_cnt` into it.
- Output-stage entries with valid=0 are not compared, so `ref_valid` gaps are tolerated.
- Reset mid-run (`rst`=0 in any state):
  - State returns to IDLE.
  - The delay line valid bits, all counters and `err_lane` go to 0.
  - `first_err_idx` goes to all-ones.
  - No partial results are preserved.

## Timing
- Reset values: `busy`=0, `done`=0, `type1_cnt`=0, `type2_cnt`=0, `checked_cnt`=0, `err_lane`=0, `first_err_idx`=all-ones.
- A ref sampled on edge t is compared with `dut_hit` sampled on edge t+`LATENCY`. The updated counters are visible after edge t+`LATENCY`.
- `start` sampled on edge s: `busy`=1 after s, and the first legal `ref_valid` is sampled on edge s+1. A `ref_valid` on edge s itself is ignored.
- With `NUM_RAYS` back-to-back issues starting at edge s+1:
  - The last issue is sampled on edge s+`NUM_RAYS`.
  - DONE is entered, with `done`=1 and `busy`=0, after edge s+`NUM_RAYS`+`LATENCY`.
- A compare and a saturation event on the same edge: the clamp applies to the new value. The saturation rule is never bypassed.
- Issue acceptance on the RUN→DRAIN edge: that issue is still counted. The transition happens after it.
- `first_err_idx` is not updated after its first load within a run, even when later mismatches occur.

## Test plan
- Bench overrides for all scenarios unless stated: `LANES`=1, `LATENCY`=38, `NUM_RAYS`=4.
- Perfect run: 4 issues with `ref_hit`=1,0,1,0, and `dut_hit` driven identically 38 cycles later → type1=0, type2=0, `checked_cnt`=4, `err_lane`=0, `first_err_idx`=15. `done` rises exactly 42 cycles after the edge following `start`.
- Mixed errors: ref=1,1,0,0 and dut=0,1,1,0 → type1=1, type2=1, `err_lane`=1, `first_err_idx`=0.
- Gaps and lanes: `LANES`=4, with `ref_valid` gapped 1-0-0-1-1-0-1. Refs 4'b1111 against duts 4'b0000 → type1=16, `checked_cnt`=4. Invalid output stages do not count.
- Saturation: `CNT_W`=3, `LANES`=4, `NUM_RAYS`=3, all refs 1 and all duts 0 → `type1_cnt` goes 4, 7, 7 and stays 7.
- Reset mid-DRAIN: pull `rst` low 10 cycles after the 4th issue → all outputs return to reset values immediately. The pipeline entries still in flight are never counted after the next `start`.
- Restart from DONE: pulse `start` with `done`=1 → counters clear, `busy`=1, and a second run gives results independent of the first. A `start` pulse during RUN has no effect.

Source files
------------

// File: rtl/ray_hit_scoreboard.sv
// Delays the reference hit bits by the ray-box pipeline latency and scores them
// against the unit outputs, keeping saturating miss/false-hit error counts.
module ray_hit_scoreboard #(
    parameter int unsigned LANES    = 1,
    parameter int unsigned LATENCY  = 38,
    parameter int unsigned NUM_RAYS = 10000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_RAYS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_valid,
    input  logic [LANES-1:0] ref_hit,
    input  logic [LANES-1:0] dut_hit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] type1_cnt,
    output logic [CNT_W-1:0] type2_cnt,
    output logic [IDX_W-1:0] checked_cnt,
    output logic [LANES-1:0] err_lane,
    output logic [IDX_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   issue_cnt;
    logic [LATENCY-1:0] pipe_vld;
    logic [LANES-1:0]   pipe_ref [LATENCY];

    logic               push_vld;
    logic               out_vld;
    logic [LANES-1:0]   out_ref;
    logic [LANES-1:0]   mism1;
    logic [LANES-1:0]   mism2;
    logic [CNT_W:0]     sum1;
    logic [CNT_W:0]     sum2;
    logic [CNT_W-1:0]   sat1;
    logic [CNT_W-1:0]   sat2;

    function automatic logic [CNT_W:0] popcnt(input logic [LANES-1:0] v);
        logic [CNT_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            c = c + (CNT_W+1)'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        push_vld = (state == RUN) && ref_valid;
        out_vld  = pipe_vld[LATENCY-1];
        out_ref  = pipe_ref[LATENCY-1];
        mism1    = out_ref & ~dut_hit;
        mism2    = ~out_ref & dut_hit;
        sum1     = {1'b0, type1_cnt} + popcnt(mism1);
        sum2     = {1'b0, type2_cnt} + popcnt(mism2);
        // carry out of the widened sum means the counter would wrap
        sat1     = sum1[CNT_W] ? '1 : sum1[CNT_W-1:0];
        sat2     = sum2[CNT_W] ? '1 : sum2[CNT_W-1:0];
    end

    // Reference payload needs no reset: only the valid bits gate its use.
    always_ff @(posedge clk) begin
        pipe_ref[0] <= ref_hit;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_ref[i] <= pipe_ref[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pipe_vld      <= '0;
            issue_cnt     <= '0;
            type1_cnt     <= '0;
            type2_cnt     <= '0;
            checked_cnt   <= '0;
            err_lane      <= '0;
            first_err_idx <= '1;
        end else begin
            pipe_vld[0] <= push_vld;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end

            if (out_vld) begin
                type1_cnt   <= sat1;
                type2_cnt   <= sat2;
                checked_cnt <= checked_cnt + IDX_W'(1);
                err_lane    <= err_lane | mism1 | mism2;
                if ((|(mism1 | mism2)) && (first_err_idx == '1)) begin
                    first_err_idx <= checked_cnt;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        issue_cnt     <= '0;
                        type1_cnt     <= '0;
                        type2_cnt     <= '0;
                        checked_cnt   <= '0;
                        err_lane      <= '0;
                        first_err_idx <= '1;
                    end
                end
                RUN: begin
                    if (ref_valid) begin
                        issue_cnt <= issue_cnt + IDX_W'(1);
                        if (issue_cnt == IDX_W'(NUM_RAYS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_vld && (checked_cnt == IDX_W'(NUM_RAYS - 1))) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_hit_scoreboard.sv
// Directed bench for ray_hit_scoreboard: three parameterisations share one clock
// and reset; an event-queue model is checked every cycle, plus literal expectations.
module tb_ray_hit_scoreboard;

    localparam int LAT = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_start [3];
    logic       in_rv    [3];
    logic [3:0] in_rh    [3];
    logic [3:0] in_dh    [3];

    logic        a_busy, a_done;
    logic [15:0] a_t1, a_t2;
    logic [3:0]  a_chk, a_fei;
    logic [0:0]  a_el;

    logic        b_busy, b_done;
    logic [15:0] b_t1, b_t2;
    logic [2:0]  b_chk, b_fei;
    logic [3:0]  b_el;

    logic        c_busy, c_done;
    logic [2:0]  c_t1, c_t2;
    logic [1:0]  c_chk, c_fei;
    logic [3:0]  c_el;

    ray_hit_scoreboard #(.LANES(1), .LATENCY(LAT), .NUM_RAYS(4), .CNT_W(16), .IDX_W(4)) u_a (
        .clk(clk), .rst(rst), .start(in_start[0]), .ref_valid(in_rv[0]),
        .ref_hit(in_rh[0][0:0]), .dut_hit(in_dh[0][0:0]),
        .busy(a_busy), .done(a_done), .type1_cnt(a_t1), .type2_cnt(a_t2),
        .checked_cnt(a_chk), .err_lane(a_el), .first_err_idx(a_fei));

    ray_hit_scoreboard #(.LANES(4), .LATENCY(LAT), .NUM_RAYS(4), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(in_start[1]), .ref_valid(in_rv[1]),
        .ref_hit(in_rh[1]), .dut_hit(in_dh[1]),
        .busy(b_busy), .done(b_done), .type1_cnt(b_t1), .type2_cnt(b_t2),
        .checked_cnt(b_chk), .err_lane(b_el), .first_err_idx(b_fei));

    ray_hit_scoreboard #(.LANES(4), .LATENCY(LAT), .NUM_RAYS(3), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .start(in_start[2]), .ref_valid(in_rv[2]),
        .ref_hit(in_rh[2]), .dut_hit(in_dh[2]),
        .busy(c_busy), .done(c_done), .type1_cnt(c_t1), .type2_cnt(c_t2),
        .checked_cnt(c_chk), .err_lane(c_el), .first_err_idx(c_fei));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int lanes_of(input int k); return (k == 0) ? 1 : 4; endfunction
    function automatic int nr_of(input int k);    return (k == 2) ? 3 : 4; endfunction
    function automatic int cmax_of(input int k);  return (k == 2) ? 7 : 65535; endfunction
    function automatic int imax_of(input int k);
        case (k)
            0:       return 15;
            1:       return 7;
            default: return 3;
        endcase
    endfunction

    // Model: run mode 0 idle, 1 issuing, 2 draining, 3 finished
    int         cyc;
    int         m_mode [3], m_iss [3], m_chk [3], m_t1 [3], m_t2 [3], m_fei [3];
    logic [3:0] m_el   [3];
    int         q_due  [3][64];
    logic [3:0] q_ref  [3][64];
    int         q_hd   [3], q_tl [3];
    logic [3:0] dh_plan [3][256];
    bit         dh_set  [3][256];

    task automatic clear_results(input int k);
        m_iss[k] = 0; m_chk[k] = 0; m_t1[k] = 0; m_t2[k] = 0;
        m_fei[k] = imax_of(k); m_el[k] = 4'h0;
    endtask

    task automatic step_model(input int k);
        int         om;
        logic [3:0] mask, r, d, mm1, mm2;
        if (!rst) begin
            clear_results(k);
            m_mode[k] = 0; q_hd[k] = 0; q_tl[k] = 0;
            return;
        end
        om   = m_mode[k];
        mask = (lanes_of(k) == 1) ? 4'h1 : 4'hF;
        if (q_hd[k] != q_tl[k] && q_due[k][q_hd[k] % 64] == cyc) begin
            r   = q_ref[k][q_hd[k] % 64];
            d   = in_dh[k] & mask;
            mm1 = r & ~d & mask;
            mm2 = ~r & d & mask;
            m_t1[k] = m_t1[k] + $countones(mm1);
            m_t2[k] = m_t2[k] + $countones(mm2);
            if (m_t1[k] > cmax_of(k)) m_t1[k] = cmax_of(k);
            if (m_t2[k] > cmax_of(k)) m_t2[k] = cmax_of(k);
            if ((mm1 | mm2) != 4'h0 && m_fei[k] == imax_of(k)) m_fei[k] = m_chk[k];
            m_el[k] = m_el[k] | mm1 | mm2;
            m_chk[k]++;
            q_hd[k]++;
            if (om == 2 && m_chk[k] == nr_of(k)) m_mode[k] = 3;
        end
        if (om == 1 && in_rv[k]) begin
            q_due[k][q_tl[k] % 64] = cyc + LAT;
            q_ref[k][q_tl[k] % 64] = in_rh[k] & mask;
            q_tl[k]++;
            m_iss[k]++;
            if (m_iss[k] == nr_of(k)) m_mode[k] = 2;
        end
        if ((om == 0 || om == 3) && in_start[k]) begin
            clear_results(k);
            m_mode[k] = 1;
        end
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            clear_results(k);
            m_mode[k] = 0; q_hd[k] = 0; q_tl[k] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) step_model(k);
        end
    end

    // Unplanned cycles drive all-ones so uncompared stages would corrupt counts.
    initial begin
        for (int k = 0; k < 3; k++) in_dh[k] = 4'h0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int slot;
                slot     = (cyc + 1) % 256;
                in_dh[k] = dh_set[k][slot] ? dh_plan[k][slot] : 4'hF;
                dh_set[k][slot] = 1'b0;
            end
        end
    end

    task automatic cmp(input int k, input logic busy, input logic done, input int t1,
                       input int t2, input int chk, input int el, input int fei);
        check($sformatf("dut%0d busy", k),  int'(busy), int'(m_mode[k] == 1 || m_mode[k] == 2));
        check($sformatf("dut%0d done", k),  int'(done), int'(m_mode[k] == 3));
        check($sformatf("dut%0d type1", k), t1,  m_t1[k]);
        check($sformatf("dut%0d type2", k), t2,  m_t2[k]);
        check($sformatf("dut%0d checked", k), chk, m_chk[k]);
        check($sformatf("dut%0d err_lane", k), el, int'(m_el[k]));
        check($sformatf("dut%0d first_err", k), fei, m_fei[k]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cmp(0, a_busy, a_done, int'(a_t1), int'(a_t2), int'(a_chk), int'(a_el), int'(a_fei));
            cmp(1, b_busy, b_done, int'(b_t1), int'(b_t2), int'(b_chk), int'(b_el), int'(b_fei));
            cmp(2, c_busy, c_done, int'(c_t1), int'(c_t2), int'(c_chk), int'(c_el), int'(c_fei));
        end
    end

    function automatic logic done_of(input int k);
        case (k)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    task automatic pulse_start(input int k, output int s);
        in_start[k] = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        in_start[k] = 1'b0;
    endtask

    task automatic issue(input int k, input bit v, input logic [3:0] r, input logic [3:0] d);
        in_rv[k] = v;
        in_rh[k] = r;
        if (v) begin
            dh_plan[k][(cyc + 1 + LAT) % 256] = d;
            dh_set[k][(cyc + 1 + LAT) % 256]  = 1'b1;
        end
        @(negedge clk);
        in_rv[k] = 1'b0;
        in_rh[k] = 4'h0;
    endtask

    task automatic wait_done(input int k, output int e);
        e = -1;
        for (int n = 0; n < 200; n++) begin
            if (done_of(k)) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        if (e < 0) check($sformatf("dut%0d done timeout", k), 0, 1);
    endtask

    task automatic wait_until(input int target);
        for (int n = 0; n < 200; n++) begin
            if (cyc >= target) break;
            @(negedge clk);
        end
        if (cyc < target) check("edge wait timeout", 0, 1);
    endtask

    initial begin
        int s, e;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_start[k] = 1'b0; in_rv[k] = 1'b0; in_rh[k] = 4'h0;
        end
        repeat (3) @(negedge clk);
        check("reset busy", int'(a_busy), 0);
        check("reset done", int'(a_done), 0);
        check("reset type1", int'(a_t1), 0);
        check("reset first_err", int'(a_fei), 15);
        check("reset first_err C", int'(c_fei), 3);
        rst = 1'b1;
        @(negedge clk);

        // perfect run
        pulse_start(0, s);
        issue(0, 1, 4'h1, 4'h1);
        issue(0, 1, 4'h0, 4'h0);
        issue(0, 1, 4'h1, 4'h1);
        issue(0, 1, 4'h0, 4'h0);
        wait_done(0, e);
        check("perfect done latency", e - s, 42);
        check("perfect type1", int'(a_t1), 0);
        check("perfect type2", int'(a_t2), 0);
        check("perfect checked", int'(a_chk), 4);
        check("perfect err_lane", int'(a_el), 0);
        check("perfect first_err", int'(a_fei), 15);

        // restart from DONE with mixed errors; start during RUN is ignored
        pulse_start(0, s);
        check("restart busy", int'(a_busy), 1);
        check("restart done", int'(a_done), 0);
        check("restart checked", int'(a_chk), 0);
        issue(0, 1, 4'h1, 4'h0);
        in_start[0] = 1'b1;
        issue(0, 1, 4'h1, 4'h1);
        in_start[0] = 1'b0;
        issue(0, 1, 4'h0, 4'h1);
        issue(0, 1, 4'h0, 4'h0);
        wait_done(0, e);
        check("mixed done latency", e - s, 42);
        check("mixed type1", int'(a_t1), 1);
        check("mixed type2", int'(a_t2), 1);
        check("mixed checked", int'(a_chk), 4);
        check("mixed err_lane", int'(a_el), 1);
        check("mixed first_err", int'(a_fei), 0);

        // gapped issues across four lanes
        pulse_start(1, s);
        issue(1, 1, 4'hF, 4'h0);
        issue(1, 0, 4'h0, 4'h0);
        issue(1, 0, 4'h0, 4'h0);
        issue(1, 1, 4'hF, 4'h0);
        issue(1, 1, 4'hF, 4'h0);
        issue(1, 0, 4'h0, 4'h0);
        issue(1, 1, 4'hF, 4'h0);
        wait_done(1, e);
        check("gaps done latency", e - s, 45);
        check("gaps type1", int'(b_t1), 16);
        check("gaps type2", int'(b_t2), 0);
        check("gaps checked", int'(b_chk), 4);
        check("gaps err_lane", int'(b_el), 15);
        check("gaps first_err", int'(b_fei), 0);

        // saturation with a 3-bit counter
        pulse_start(2, s);
        issue(2, 1, 4'hF, 4'h0);
        issue(2, 1, 4'hF, 4'h0);
        issue(2, 1, 4'hF, 4'h0);
        wait_until(s + LAT + 1);
        check("sat type1 first", int'(c_t1), 4);
        @(negedge clk);
        check("sat type1 second", int'(c_t1), 7);
        check("sat not done yet", int'(c_done), 0);
        @(negedge clk);
        check("sat type1 third", int'(c_t1), 7);
        check("sat done", int'(c_done), 1);
        repeat (3) @(negedge clk);
        check("sat type1 held", int'(c_t1), 7);
        check("sat checked", int'(c_chk), 3);

        // reset while draining, then a clean run
        pulse_start(0, s);
        for (int i = 0; i < 4; i++) issue(0, 1, 4'h1, 4'h0);
        wait_until(s + 14);
        check("pre-reset busy", int'(a_busy), 1);
        rst = 1'b0;
        #1;
        check("mid reset busy", int'(a_busy), 0);
        check("mid reset done", int'(a_done), 0);
        check("mid reset checked", int'(a_chk), 0);
        check("mid reset first_err", int'(a_fei), 15);
        check("mid reset clears B type1", int'(b_t1), 0);
        check("mid reset clears C done", int'(c_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(0, s);
        for (int i = 0; i < 4; i++) issue(0, 1, 4'h0, 4'h0);
        wait_done(0, e);
        check("post-reset done latency", e - s, 42);
        check("post-reset type1", int'(a_t1), 0);
        check("post-reset type2", int'(a_t2), 0);
        check("post-reset checked", int'(a_chk), 4);
        check("post-reset first_err", int'(a_fei), 15);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
